detect_window_ctrl: RTL
=======================

// Module: detect_window_ctrl
// PURPOSE
//   Run controller for the LFSR + sequence-detector datapath. Reseeds the LFSR, advances
//   LFSR/detector on the divided-clock tick for a fixed window of steps, counts detector
//   hits in 4-digit BCD, latches the result to the display digits d3..d0 and holds it.
//   Sits in top between the clock divider (tick), the LFSR, the detector and the display mux.
// PARAMETERS
//   WINDOW_STEPS  1000  LFSR steps per measurement window (>=1, < 2**STEP_W)
//   HOLD_TICKS    50    ticks the latched result is held before leaving HOLD (>=1)
//   STEP_W        16    width of step and hold counters
// PORTS
//   CCLK       in   1  system clock, all logic on rising edge
//   reset      in   1  asynchronous, active-high reset
//   start      in   1  level; sampled in IDLE only
//   tick       in   1  1-cycle enable from clock divider (max_tick)
//   det_pulse  in   1  1-cycle hit from sequence detector
//   lfsr_load  out  1  1-cycle reseed strobe to LFSR
//   step_en    out  1  advance enable to LFSR and detector
//   busy       out  1  high whenever state != IDLE
//   done       out  1  1-cycle pulse when result latched
//   ovf        out  1  hit count saturated in current/last window
//   d3,d2,d1,d0 out 4 each  latched BCD hit count, d3 = thousands
// BEHAVIOUR
//   Reset (async): state IDLE; all outputs 0; step/hold counters and running BCD = 0.
//   FSM states IDLE, SEED, RUN, HOLD (registered):
//   - IDLE: start=1 -> SEED next cycle. tick/det_pulse ignored.
//   - SEED: exactly 1 cycle; lfsr_load=1; running BCD, step counter, ovf cleared -> RUN.
//   - RUN: step_en = tick (combinational, gated by state==RUN; zero latency).
//     Each step_en increments step counter. det_pulse in RUN increments running BCD
//     (any cycle, including the cycle of the final step).
//     On the WINDOW_STEPS-th step: next cycle state HOLD, d3..d0 <= running BCD
//     (including a hit in that same cycle), done=1 for that one cycle.
//   - HOLD: d3..d0 frozen; hold counter counts ticks; after HOLD_TICKS-th tick -> IDLE.
//   start ignored in SEED/RUN/HOLD; det_pulse ignored outside RUN.
//   BCD rules: per-digit 9 -> 0 with carry; at 9999 further hits saturate at 9999 and
//   set ovf (sticky until next SEED). d3..d0 only change at latch, SEED leaves them intact.
//   tick and det_pulse same cycle: both honoured. Reset mid-RUN/HOLD: immediate IDLE,
//   d3..d0 cleared, no done pulse.
// CONFIGURATION
//   AUTO_RESTART_EN defined: HOLD exit goes to SEED (continuous measurement loop,
//     start needed only once after reset); busy stays high.
//   AUTO_RESTART_EN undefined: HOLD exit goes to IDLE; new start required.
// TESTING (WINDOW_STEPS=8, HOLD_TICKS=3, tick every 4th cycle)
//   1 reset held 2 cycles, start=0 -> all outputs 0, busy=0, lfsr_load never asserted.
//   2 start pulse, 3 det_pulse in RUN -> lfsr_load 1 cycle, 8 step_en pulses, done once,
//     d3..d0 = 0,0,0,3; after 3 ticks busy=0.
//   3 det_pulse coincident with 8th tick -> counted; d0=1; det_pulse in IDLE/HOLD -> no change.
//   4 WINDOW_STEPS=20000, det_pulse every cycle -> d=9,9,9,9, ovf=1; next SEED clears ovf.
//   5 reset asserted mid-RUN after 5 steps -> busy=0, d=0 same cycle, no done; restart works.
//   6 AUTO_RESTART_EN: single start -> second lfsr_load 1 cycle after hold ends, busy stays 1.

Source files
------------

// File: rtl/detect_window_ctrl.sv
// -----------------------------------------------------------------------------
// detect_window_ctrl
//   Run controller for the LFSR + sequence-detector datapath. A start request
//   reseeds the LFSR and then advances the LFSR and detector on each divider
//   tick for WINDOW_STEPS steps. Detector hits are counted in 4-digit BCD,
//   saturating at 9999. At the end of the window the count is latched to the
//   display digits and held for HOLD_TICKS ticks.
//
// Parameters
//   WINDOW_STEPS  LFSR steps per measurement window (>=1, < 2**STEP_W)
//   HOLD_TICKS    ticks the latched result is held before leaving HOLD (>=1)
//   STEP_W        width of the step and hold counters
//
// Ports
//   CCLK        in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   level start request, sampled in IDLE only
//   tick        in   1-cycle enable from the clock divider
//   det_pulse   in   1-cycle hit from the sequence detector
//   lfsr_load   out  1-cycle reseed strobe to the LFSR (SEED state)
//   step_en     out  advance enable to LFSR and detector (tick gated by RUN)
//   busy        out  high whenever the FSM is not IDLE
//   done        out  1-cycle pulse in the cycle the result becomes visible
//   ovf         out  hit count saturated in the current/last window
//   d3..d0      out  latched BCD hit count, d3 = thousands
//
// Build option
//   AUTO_RESTART_EN  when defined, leaving HOLD reseeds and starts the next
//                    window directly (busy stays high); otherwise the FSM
//                    returns to IDLE and waits for a new start.
// -----------------------------------------------------------------------------
module detect_window_ctrl #(
  parameter int WINDOW_STEPS = 1000,
  parameter int HOLD_TICKS   = 50,
  parameter int STEP_W       = 16
) (
  input  logic       CCLK,
  input  logic       reset,
  input  logic       start,
  input  logic       tick,
  input  logic       det_pulse,
  output logic       lfsr_load,
  output logic       step_en,
  output logic       busy,
  output logic       done,
  output logic       ovf,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_RUN  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW_STEPS - 1);
  localparam logic [STEP_W-1:0] LAST_HOLD = STEP_W'(HOLD_TICKS - 1);
  localparam logic [STEP_W-1:0] CNT_ONE   = STEP_W'(1);
  localparam logic [15:0]       BCD_MAX   = 16'h9999;

  // Increment a 4-digit BCD value; each digit wraps 9 -> 0 and carries.
  // Saturation at 9999 is handled by the caller.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [STEP_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]       bcd_q, bcd_d;
  logic [15:0]       disp_q, disp_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              in_run;
  logic              step;
  logic              last_step;
  logic              hit;
  logic              bcd_sat;
  logic [15:0]       bcd_nxt;

  // Step and hit qualification shared by the FSM and the counters.
  assign in_run    = (state_q == S_RUN);
  assign step      = tick & in_run;
  assign last_step = step && (step_cnt_q == LAST_STEP);
  assign hit       = det_pulse & in_run;
  assign bcd_sat   = (bcd_q == BCD_MAX);
  // Count including a hit in this cycle, so a hit on the final step is latched.
  assign bcd_nxt   = (hit && !bcd_sat) ? bcd_inc(bcd_q) : bcd_q;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_SEED;
      S_SEED: state_d = S_RUN;
      S_RUN:  if (last_step) state_d = S_HOLD;
      S_HOLD: begin
        if (tick && (hold_cnt_q == LAST_HOLD)) begin
`ifdef AUTO_RESTART_EN
          state_d = S_SEED;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    lfsr_load = (state_q == S_SEED);
    step_en   = step;
    busy      = (state_q != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Counters, running BCD and display latch
  // ---------------------------------------------------------------------------
  always_comb begin
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_SEED: begin
        // Display digits deliberately untouched: last result stays visible.
        step_cnt_d = '0;
        bcd_d      = '0;
        ovf_d      = 1'b0;
      end
      S_RUN: begin
        bcd_d = bcd_nxt;
        if (hit && bcd_sat) ovf_d = 1'b1;
        if (step) step_cnt_d = step_cnt_q + CNT_ONE;
        if (last_step) begin
          disp_d     = bcd_nxt;
          done_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        if (tick) hold_cnt_d = hold_cnt_q + CNT_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CCLK or posedge reset) begin
    if (reset) begin
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      bcd_q      <= '0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      bcd_q      <= bcd_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign done = done_q;
  assign ovf  = ovf_q;
  assign d3   = disp_q[15:12];
  assign d2   = disp_q[11:8];
  assign d1   = disp_q[7:4];
  assign d0   = disp_q[3:0];

endmodule
